// File: rtl/timer_defs.sv
// Shared constants and helpers for the microwave countdown timer.
// BCD digit width/limits and the derived timer operating state.
package timer_defs;

   localparam int BCD_W = 4;

   localparam logic [BCD_W-1:0] DIG_MAX9 = 4'd9;
   localparam logic [BCD_W-1:0] DIG_MAX5 = 4'd5;
   localparam logic [BCD_W-1:0] BCD_ZERO = 4'd0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SET,
      ST_RUN
   } timer_state_e;

   function automatic logic is_bcd(input logic [BCD_W-1:0] d);
      return (d <= DIG_MAX9);
   endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD digit of the countdown: sync clear, parallel load, borrow-chained
// decrement (wrapping 0 -> MAX) and keypad shift-in, in that priority.
module bcd_down_digit
   import timer_defs::*;
#(
   parameter logic [BCD_W-1:0] MAX = DIG_MAX9
) (
   input  logic             clk,
   input  logic             Nreset,
   input  logic             clr,
   input  logic             load,
   input  logic [BCD_W-1:0] load_val,
   input  logic             shift_en,
   input  logic [BCD_W-1:0] shift_in,
   input  logic             dec_en,
   input  logic             borrow_in,
   output logic [BCD_W-1:0] digit,
   output logic             borrow_out
);

   logic [BCD_W-1:0] digit_reg;
   logic [BCD_W-1:0] digit_next;

   // Borrow ripples on to the next digit only while this one is already zero.
   assign borrow_out = borrow_in && (digit_reg == BCD_ZERO);

   always_comb begin
      digit_next = digit_reg;
      if (clr) begin
         digit_next = BCD_ZERO;
      end else if (load) begin
         digit_next = load_val;
      end else if (dec_en && borrow_in) begin
         digit_next = (digit_reg == BCD_ZERO) ? MAX : digit_reg - 4'd1;
      end else if (shift_en) begin
         digit_next = shift_in;
      end
   end

   always_ff @(posedge clk or negedge Nreset) begin
      if (!Nreset) begin
         digit_reg <= BCD_ZERO;
      end else begin
         digit_reg <= digit_next;
      end
   end

   assign digit = digit_reg;

endmodule

// File: rtl/mag_countdown_timer.sv
// MM:SS cooking-time countdown: keypad digits shift in while idle, one second
// is removed every TICK_DIV clocks while the magnetron runs, expiry is flagged.
module mag_countdown_timer
   import timer_defs::*;
#(
   parameter int TICK_DIV = 100
) (
   input  logic             clk,
   input  logic             Nreset,
   input  logic             Nclear,
   input  logic             key_valid,
   input  logic [BCD_W-1:0] key_digit,
   input  logic             mag_on,
   output logic [BCD_W-1:0] min_tens,
   output logic [BCD_W-1:0] min_ones,
   output logic [BCD_W-1:0] sec_tens,
   output logic [BCD_W-1:0] sec_ones,
   output logic             time_over,
   output logic             done_pulse
);

   localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

   logic [PRESC_W-1:0] presc_reg;
   logic [PRESC_W-1:0] presc_next;
   logic               done_reg;
   logic               done_next;
   timer_state_e       timer_state;
   logic               tick;
   logic               key_ok;
   logic               at_one_sec;

   // Index 0 = sec_ones ... index 3 = min_tens.
   logic [BCD_W-1:0]   digit_q   [4];
   logic [BCD_W-1:0]   shift_src [4];
   logic [4:0]         borrow_chain;

   assign borrow_chain[0] = 1'b1;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_digit
         if (gi == 0) begin : g_src_key
            assign shift_src[gi] = key_digit;
         end else begin : g_src_prev
            assign shift_src[gi] = digit_q[gi-1];
         end

         bcd_down_digit #(
            .MAX((gi == 1) ? DIG_MAX5 : DIG_MAX9)
         ) u_digit (
            .clk       (clk),
            .Nreset    (Nreset),
            .clr       (!Nclear),
            .load      (1'b0),
            .load_val  (BCD_ZERO),
            .shift_en  (key_ok),
            .shift_in  (shift_src[gi]),
            .dec_en    (tick),
            .borrow_in (borrow_chain[gi]),
            .digit     (digit_q[gi]),
            .borrow_out(borrow_chain[gi+1])
         );
      end
   endgenerate

   // With a constant borrow into sec_ones, a borrow escaping min_tens means every digit is zero.
   assign time_over = borrow_chain[4];

   assign at_one_sec = ({digit_q[3], digit_q[2], digit_q[1], digit_q[0]} == 16'h0001);

   always_comb begin
      timer_state = ST_SET;
      if (time_over) begin
         timer_state = ST_IDLE;
      end else if (mag_on) begin
         timer_state = ST_RUN;
      end
   end

   assign tick   = (timer_state == ST_RUN) && (presc_reg == PRESC_LAST);
   assign key_ok = key_valid && is_bcd(key_digit) && !mag_on;

   // Partial seconds are discarded whenever the count is not running.
   always_comb begin
      presc_next = presc_reg;
      done_next  = 1'b0;
      if (!Nclear) begin
         presc_next = '0;
      end else if (timer_state != ST_RUN) begin
         presc_next = '0;
      end else if (presc_reg == PRESC_LAST) begin
         presc_next = '0;
         done_next  = at_one_sec;
      end else begin
         presc_next = presc_reg + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge Nreset) begin
      if (!Nreset) begin
         presc_reg <= '0;
         done_reg  <= 1'b0;
      end else begin
         presc_reg <= presc_next;
         done_reg  <= done_next;
      end
   end

   assign done_pulse = done_reg;
   assign sec_ones   = digit_q[0];
   assign sec_tens   = digit_q[1];
   assign min_ones   = digit_q[2];
   assign min_tens   = digit_q[3];

endmodule
